// File: rtl/storage_packet_tx_if.sv
// rtl/storage_packet_tx_if.sv - storage read port and link byte port of the packet transmitter
interface storage_packet_tx_if;
    logic [7:0] StorageData;
    logic       StorageValid;
    logic       StorageReady;
    logic       StorageReadEnable;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;

    modport master (
        input  StorageData, StorageValid, StorageReady, TxReady,
        output StorageReadEnable, TxData, TxValid
    );

    modport slave (
        output StorageData, StorageValid, StorageReady, TxReady,
        input  StorageReadEnable, TxData, TxValid
    );
endinterface

// File: rtl/storage_packet_tx.sv
// rtl/storage_packet_tx.sv - frames storage bytes into header/sequence/payload packets for the host link
// Define PKT_CHECKSUM_EN to append a two's-complement checksum byte to every packet.
module storage_packet_tx #(
    parameter int unsigned PACKET_BYTES = 256,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic                ReadClock,
    input  logic                Reset,
    storage_packet_tx_if.master bus,
    output logic                Busy,
    output logic [15:0]         PacketCount
);
    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        SEQ,
        PAYLOAD
`ifdef PKT_CHECKSUM_EN
        , CHECKSUM
`endif
    } state_t;

    localparam logic [16:0] PacketLen = 17'(PACKET_BYTES);

    state_t      state, stateNext;
    logic [7:0]  seqNum;
    logic [15:0] payloadCount;
    logic [7:0]  holdData;
    logic        holdFull;
    logic        readPending;
    logic        lastPayload;
    logic        payloadFire;
    logic        packetDone;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]  checksumAcc;
`endif

    assign lastPayload = (({1'b0, payloadCount} + 17'd1) == PacketLen);
    assign payloadFire = (state == PAYLOAD) && holdFull && bus.TxReady;
`ifdef PKT_CHECKSUM_EN
    assign packetDone  = (state == CHECKSUM) && bus.TxReady;
`else
    assign packetDone  = payloadFire && lastPayload;
`endif
    assign Busy = (state != IDLE);

    always_comb begin
        stateNext             = state;
        bus.TxValid           = 1'b0;
        bus.TxData            = 8'h00;
        bus.StorageReadEnable = 1'b0;
        case (state)
            IDLE: begin
                if (bus.StorageReady) stateNext = HEADER;
            end
            HEADER: begin
                bus.TxValid = 1'b1;
                bus.TxData  = HEADER_BYTE;
                if (bus.TxReady) stateNext = SEQ;
            end
            SEQ: begin
                bus.TxValid = 1'b1;
                bus.TxData  = seqNum;
                if (bus.TxReady) stateNext = PAYLOAD;
            end
            PAYLOAD: begin
                bus.TxValid = holdFull;
                bus.TxData  = holdFull ? holdData : 8'h00;
                // Single outstanding read; gated by Reset so an aborting cycle never pops storage.
                bus.StorageReadEnable = !Reset && !holdFull && !readPending && bus.StorageReady &&
                    (({1'b0, payloadCount} + {16'd0, readPending} + {16'd0, holdFull}) < PacketLen);
                if (payloadFire && lastPayload) begin
`ifdef PKT_CHECKSUM_EN
                    stateNext = CHECKSUM;
`else
                    stateNext = IDLE;
`endif
                end
            end
`ifdef PKT_CHECKSUM_EN
            CHECKSUM: begin
                bus.TxValid = 1'b1;
                bus.TxData  = 8'h00 - checksumAcc;
                if (bus.TxReady) stateNext = IDLE;
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge ReadClock) begin
        if (Reset) begin
            state        <= IDLE;
            seqNum       <= 8'h00;
            PacketCount  <= 16'h0000;
            payloadCount <= 16'h0000;
            holdData     <= 8'h00;
            holdFull     <= 1'b0;
            readPending  <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            checksumAcc  <= 8'h00;
`endif
        end else begin
            state <= stateNext;
            if ((state == SEQ) && bus.TxReady) begin
                payloadCount <= 16'h0000;
`ifdef PKT_CHECKSUM_EN
                checksumAcc  <= 8'h00;
`endif
            end
            // A StorageValid without an outstanding read is stray and must not disturb the holding register.
            if (bus.StorageReadEnable) begin
                readPending <= 1'b1;
            end else if (readPending && bus.StorageValid) begin
                holdData    <= bus.StorageData;
                holdFull    <= 1'b1;
                readPending <= 1'b0;
            end
            if (payloadFire) begin
                holdFull     <= 1'b0;
                payloadCount <= payloadCount + 16'd1;
`ifdef PKT_CHECKSUM_EN
                checksumAcc  <= checksumAcc + holdData;
`endif
            end
            if (packetDone) begin
                PacketCount <= PacketCount + 16'd1;
                seqNum      <= seqNum + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_storage_packet_tx.sv
// tb/tb_storage_packet_tx.sv - self-checking bench for storage_packet_tx with a byte-queue packet model
module tb_storage_packet_tx;
    localparam int PB = 4;
`ifdef PKT_CHECKSUM_EN
    localparam int PKT_LEN = PB + 3;
`else
    localparam int PKT_LEN = PB + 2;
`endif

    logic        ReadClock = 1'b0;
    logic        Reset     = 1'b1;
    logic        Busy;
    logic [15:0] PacketCount;

    storage_packet_tx_if bus();

    storage_packet_tx #(.PACKET_BYTES(PB), .HEADER_BYTE(8'hA5)) dut (
        .ReadClock  (ReadClock),
        .Reset      (Reset),
        .bus        (bus.master),
        .Busy       (Busy),
        .PacketCount(PacketCount)
    );

    always #5 ReadClock = ~ReadClock;

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Storage: byte queue, read data returned one cycle after the pop request.
    logic [7:0] storeQ[$];
    logic       rdReq     = 1'b0;
    bit         txToggle  = 1'b0;

    always @(negedge ReadClock) rdReq = bus.StorageReadEnable;

    initial begin
        bus.StorageData  = 8'h00;
        bus.StorageValid = 1'b0;
        bus.StorageReady = 1'b0;
        bus.TxReady      = 1'b1;
        forever begin
            @(posedge ReadClock);
            #1;
            if (rdReq && storeQ.size() > 0) begin
                bus.StorageData  = storeQ.pop_front();
                bus.StorageValid = 1'b1;
            end else begin
                bus.StorageValid = 1'b0;
            end
            bus.StorageReady = (storeQ.size() > 0);
            bus.TxReady      = txToggle ? ~bus.TxReady : 1'b1;
        end
    end

    // Packet model: expected wire bytes with end-of-packet markers.
    logic [7:0] expQ[$];
    bit         expLast[$];
    logic [7:0] expSeq     = 8'h00;
    int         modelCount = 0;
    logic [7:0] logQ[$];
    int         rdCount    = 0;
    int         validCycles = 0;
    logic       prevStall  = 1'b0;
    logic [7:0] prevData   = 8'h00;

    task automatic expectPacket(input logic [7:0] pay[$], input int keep);
        logic [7:0] pk[$];
        logic [7:0] sum;
        int         k;
        sum = 8'h00;
        pk.push_back(8'hA5);
        pk.push_back(expSeq);
        foreach (pay[i]) begin
            pk.push_back(pay[i]);
            sum = sum + pay[i];
        end
`ifdef PKT_CHECKSUM_EN
        pk.push_back(8'h00 - sum);
`endif
        k = (keep < 0) ? pk.size() : keep;
        for (int i = 0; i < k; i++) begin
            expQ.push_back(pk[i]);
            expLast.push_back(i == pk.size() - 1);
        end
        if (k == pk.size()) expSeq = expSeq + 8'd1;
    endtask

    always @(negedge ReadClock) begin
        if (!Reset) begin
            if (bus.StorageReadEnable) rdCount++;
            if (bus.TxValid) validCycles++;
            check("packet_count", {16'h0, PacketCount}, modelCount & 32'hFFFF);
            if (prevStall) begin
                check("stall_valid", {31'h0, bus.TxValid}, 32'd1);
                check("stall_data", {24'h0, bus.TxData}, {24'h0, prevData});
            end
            if (bus.TxValid && bus.TxReady) begin
                logQ.push_back(bus.TxData);
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL unexpected_byte: got %0h with no byte expected", bus.TxData);
                end else begin
                    check("tx_byte", {24'h0, bus.TxData}, {24'h0, expQ.pop_front()});
                    if (expLast.pop_front()) modelCount++;
                end
            end
            prevStall = bus.TxValid && !bus.TxReady;
            prevData  = bus.TxData;
        end else begin
            prevStall = 1'b0;
        end
    end

    task automatic pushStore(input logic [7:0] b[$]);
        foreach (b[i]) storeQ.push_back(b[i]);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            @(negedge ReadClock);
            #1;
            n++;
            done = (expQ.size() == 0) && !Busy && (storeQ.size() == 0);
        end
        check(name, {31'h0, done}, 32'd1);
    endtask

    task automatic waitLog(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (logQ.size() < target && n < budget) begin
            @(negedge ReadClock);
            #1;
            n++;
        end
        check(name, logQ.size(), target);
    endtask

    task automatic checkLog(input string name, input int base, input logic [7:0] lit[$]);
        foreach (lit[i]) begin
            if (base + i < logQ.size()) check(name, {24'h0, logQ[base + i]}, {24'h0, lit[i]});
            else check(name, base + i, logQ.size());
        end
    endtask

    task automatic resetDut();
        @(posedge ReadClock);
        #1;
        Reset = 1'b1;
        storeQ.delete();
        expQ.delete();
        expLast.delete();
        expSeq     = 8'h00;
        modelCount = 0;
        @(posedge ReadClock);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pay[$];
        logic [7:0] lit[$];
        int         base;
        int         rd0;
        int         vc0;

        repeat (3) @(posedge ReadClock);
        @(negedge ReadClock);
        check("reset_txvalid", {31'h0, bus.TxValid}, 32'd0);
        check("reset_txdata", {24'h0, bus.TxData}, 32'h00);
        check("reset_rden", {31'h0, bus.StorageReadEnable}, 32'd0);
        check("reset_busy", {31'h0, Busy}, 32'd0);
        check("reset_count", {16'h0, PacketCount}, 32'd0);
        @(posedge ReadClock);
        #1;
        Reset = 1'b0;

        // 1: continuous ready
        base = logQ.size();
        rd0  = rdCount;
        pay  = '{8'h01, 8'h02, 8'h03, 8'h04};
        expectPacket(pay, -1);
        pushStore(pay);
        waitIdle("t1_done", 200);
`ifdef PKT_CHECKSUM_EN
        lit = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
`else
        lit = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
        checkLog("t1_bytes", base, lit);
        check("t1_len", logQ.size() - base, PKT_LEN);
        check("t1_count", {16'h0, PacketCount}, 32'd1);
        check("t1_busy", {31'h0, Busy}, 32'd0);
        check("t1_reads", rdCount - rd0, 4);

        // 2: TxReady toggling
        txToggle = 1'b1;
        base = logQ.size();
        expectPacket(pay, -1);
        pushStore(pay);
        waitIdle("t2_done", 300);
        txToggle = 1'b0;
`ifdef PKT_CHECKSUM_EN
        lit = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
`else
        lit = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
        checkLog("t2_bytes", base, lit);
        check("t2_len", logQ.size() - base, PKT_LEN);
        check("t2_count", {16'h0, PacketCount}, 32'd2);

        // 3: storage underrun mid-packet
        base = logQ.size();
        rd0  = rdCount;
        pay  = '{8'h10, 8'h20, 8'h30, 8'h40};
        expectPacket(pay, -1);
        lit  = '{8'h10, 8'h20};
        pushStore(lit);
        waitLog("t3_first_half", base + 4, 100);
        repeat (3) @(negedge ReadClock);
        vc0 = validCycles;
        check("t3_stall_reads", rdCount - rd0, 2);
        repeat (20) @(negedge ReadClock);
        check("t3_stall_valid", validCycles - vc0, 0);
        check("t3_stall_reads_after", rdCount - rd0, 2);
        check("t3_stall_busy", {31'h0, Busy}, 32'd1);
        lit = '{8'h30, 8'h40};
        pushStore(lit);
        waitIdle("t3_done", 200);
`ifdef PKT_CHECKSUM_EN
        lit = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h60};
`else
        lit = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40};
`endif
        checkLog("t3_bytes", base, lit);
        check("t3_reads", rdCount - rd0, 4);

        // 4: 257 packets, sequence wraps
        resetDut();
        pay = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int p = 0; p < 257; p++) begin
            base = logQ.size();
            expectPacket(pay, -1);
            pushStore(pay);
            waitIdle("t4_done", 200);
        end
        check("t4_seq_wrap", {24'h0, logQ[base + 1]}, 32'h00);
        check("t4_count", {16'h0, PacketCount}, 32'd257);

        // 5: reset after second payload byte
        base = logQ.size();
        pay  = '{8'h01, 8'h02, 8'h03, 8'h04};
        expectPacket(pay, 4);
        pushStore(pay);
        waitLog("t5_partial", base + 4, 100);
        resetDut();
        @(negedge ReadClock);
        check("t5_txvalid", {31'h0, bus.TxValid}, 32'd0);
        check("t5_rden", {31'h0, bus.StorageReadEnable}, 32'd0);
        check("t5_busy", {31'h0, Busy}, 32'd0);
        check("t5_count", {16'h0, PacketCount}, 32'd0);
        base = logQ.size();
        pay  = '{8'h05, 8'h06, 8'h07, 8'h08};
        expectPacket(pay, -1);
        pushStore(pay);
        waitIdle("t5_done", 200);
        lit = '{8'hA5, 8'h00, 8'h05, 8'h06};
        checkLog("t5_restart", base, lit);
        check("t5_len", logQ.size() - base, PKT_LEN);
        check("t5_count_after", {16'h0, PacketCount}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
